// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port sequencer/arbiter for a shared single-port nibble RAM
//
// Purpose:
//   Shares one 4-bit x 256 single-port RAM and its tristate data bus between
//   port A (CPU datapath) and port B (loader/debug). Each access runs
//   IDLE -> ACCESS -> [CAPTURE] -> DONE and ends with a one-cycle ack pulse.
//
// Configuration:
//   ARB_ROUND_ROBIN_EN - defined: on contention the port that was not granted
//                        last wins. Undefined: port A always wins contention.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request (held until a_ack)
//   a_ack, a_rdata             port A one-cycle ack, read data
//   b_*                        same set for port B
//   ram_addr, ram_we           registered RAM address and write enable
//   ram_wdata, ram_wdata_oe    write data and bus driver enable
//   ram_rdata                  shared data bus as seen by this block
//   busy                       high whenever the FSM is not IDLE

module ram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_wdata_oe,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  state_t        r_state;
  logic          r_grant;
  logic          r_last_grant;
  logic [AW-1:0] r_ram_addr;
  logic          r_ram_we;
  logic [DW-1:0] r_ram_wdata;
  logic          r_ram_wdata_oe;
  logic          r_a_ack;
  logic          r_b_ack;
  logic [DW-1:0] r_a_rdata;
  logic [DW-1:0] r_b_rdata;
  logic [DW-1:0] r_capture;
  logic          w_win_b;

  // Winner selection; only consumed in IDLE.
  always_comb begin
    w_win_b = 1'b0;
    if (a_req && b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      w_win_b = (r_last_grant == GNT_A);
`else
      // Fixed priority: A wins; the grant history is tracked but ignored.
      w_win_b = 1'b0 & r_last_grant;
`endif
    end else begin
      w_win_b = b_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_grant        <= GNT_A;
      r_last_grant   <= GNT_B;   // so A wins the first contention
      r_ram_addr     <= '0;
      r_ram_we       <= 1'b0;
      r_ram_wdata    <= '0;
      r_ram_wdata_oe <= 1'b0;
      r_a_ack        <= 1'b0;
      r_b_ack        <= 1'b0;
      r_a_rdata      <= '0;
      r_b_rdata      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (a_req || b_req) begin
            r_state        <= ACCESS;
            r_grant        <= w_win_b;
            r_last_grant   <= w_win_b;
            r_ram_addr     <= w_win_b ? b_addr  : a_addr;
            r_ram_wdata    <= w_win_b ? b_wdata : a_wdata;
            r_ram_we       <= w_win_b ? b_we    : a_we;
            r_ram_wdata_oe <= w_win_b ? b_we    : a_we;
          end
        end
        ACCESS: begin
          if (r_ram_we) begin
            // RAM wrote at the mid-cycle negedge; release we and the bus
            // driver on the same edge so the driver never outlives we.
            r_ram_we       <= 1'b0;
            r_ram_wdata_oe <= 1'b0;
            r_a_ack        <= (r_grant == GNT_A);
            r_b_ack        <= (r_grant == GNT_B);
            r_state        <= DONE;
          end else begin
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          // r_capture was loaded at the negedge inside this cycle.
          r_a_ack <= (r_grant == GNT_A);
          r_b_ack <= (r_grant == GNT_B);
          if (r_grant == GNT_A) r_a_rdata <= r_capture;
          else                  r_b_rdata <= r_capture;
          r_state <= DONE;
        end
        DONE: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The RAM only drives the bus while clk is high, so read data is taken
  // on the falling edge of the CAPTURE cycle.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_capture <= '0;
    end else if (r_state == CAPTURE) begin
      r_capture <= ram_rdata;
    end
  end

  assign a_ack        = r_a_ack;
  assign b_ack        = r_b_ack;
  assign a_rdata      = r_a_rdata;
  assign b_rdata      = r_b_rdata;
  assign ram_addr     = r_ram_addr;
  assign ram_we       = r_ram_we;
  assign ram_wdata    = r_ram_wdata;
  assign ram_wdata_oe = r_ram_wdata_oe;
  assign busy         = (r_state != IDLE);

endmodule
